square_game_logic: RTL and testbench

SQUARE_GAME_LOGIC -- requirements
Module: square_game_logic

---
 rtl/square_game_logic.sv | 207 ++++++++++++++++++++
 tb/tb_square_game_logic.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_game_logic.sv
// Tilt-steered square chase game: move the player onto a random target and hold it there to score.
// Latency: state updates 1 clk after start; positions/score 1 clk after frame_tick (2 after screenEnd).
// Backpressure: none; free-running per clock, no handshake on any input.
module square_game_logic #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int HALF_PLAYER = 25,
    parameter int HALF_TARGET = 30,
    parameter int DEADZONE    = 16,
    parameter int SHIFT       = 6,
    parameter int HOLD_FRAMES = 30,
    parameter int WIN_SCORE   = 5
) (
    input  logic               clk_25mHz,
    input  logic               reset,
    input  logic               screenEnd,
    input  logic signed [11:0] tilt_x,
    input  logic signed [11:0] tilt_y,
    input  logic               BTNU,
    output logic [31:0]        accel_x,
    output logic [31:0]        accel_y,
    output logic [31:0]        target_x,
    output logic [31:0]        target_y,
    output logic [31:0]        game_state,
    output logic [7:0]         score
);

    typedef enum logic [1:0] {
        ST_WIN   = 2'd0,
        ST_PLAY  = 2'd1,
        ST_READY = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic signed [12:0] X_MIN = 13'(HALF_PLAYER);
    localparam logic signed [12:0] X_MAX = 13'(WIDTH - 1 - HALF_PLAYER);
    localparam logic signed [12:0] Y_MIN = 13'(HALF_PLAYER);
    localparam logic signed [12:0] Y_MAX = 13'(HEIGHT - 1 - HALF_PLAYER);
    localparam logic signed [12:0] X_CTR = 13'(WIDTH / 2);
    localparam logic signed [12:0] Y_CTR = 13'(HEIGHT / 2);
    localparam logic signed [12:0] DZ    = 13'(DEADZONE);
    localparam logic signed [12:0] REACH = 13'(HALF_TARGET - HALF_PLAYER);
    localparam logic signed [12:0] HT    = 13'(HALF_TARGET);
    localparam logic signed [12:0] L_LIM = 13'(WIDTH - 1 - 2 * HALF_TARGET);
    localparam logic signed [12:0] M_LIM = 13'(HEIGHT - 1 - 2 * HALF_TARGET);
    localparam logic [15:0]        HOLD_LAST = 16'(HOLD_FRAMES - 1);
    localparam logic [7:0]         WIN_SC    = 8'(WIN_SCORE);

    logic               btn_s1, btn_s2, btn_s3;
    logic               frame_tick;
    logic               start;
    logic [15:0]        lfsr_q;
    state_t             state_q, state_d;
    logic signed [12:0] px_q, py_q, tx_q, ty_q;
    logic signed [12:0] px_d, py_d, tx_d, ty_d;
    logic [15:0]        hold_q, hold_d;
    logic [7:0]         score_q, score_d;
    logic signed [12:0] nx, ny, tx_new, ty_new, lv, mv;
    logic               overlap;
    logic [7:0]         score_inc;

    // Tilt to per-frame step: small readings are noise, larger ones scale down keeping sign.
    function automatic logic signed [12:0] tilt_step(input logic signed [11:0] t);
        logic signed [12:0] t13;
        logic signed [12:0] mag;
        t13 = {t[11], t};
        mag = t13[12] ? -t13 : t13;
        if (mag <= DZ) return '0;
        return t13 >>> SHIFT;
    endfunction

    function automatic logic signed [12:0] clamp(input logic signed [12:0] v,
                                                  input logic signed [12:0] lo,
                                                  input logic signed [12:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic signed [12:0] iabs(input logic signed [12:0] v);
        return v[12] ? -v : v;
    endfunction

    // Button synchroniser, edge detect history, and frame boundary register.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            btn_s3     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            btn_s1     <= BTNU;
            btn_s2     <= btn_s1;
            btn_s3     <= btn_s2;
            frame_tick <= screenEnd;
        end
    end

    assign start = btn_s2 & ~btn_s3;

    // Free-running random source for target placement; the seed keeps it off the all-zero lockup.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Candidate motion, overlap test and next target, all derived from current registers.
    always_comb begin
        nx        = clamp(px_q + tilt_step(tilt_x), X_MIN, X_MAX);
        ny        = clamp(py_q + tilt_step(tilt_y), Y_MIN, Y_MAX);
        overlap   = (iabs(nx - tx_q) <= REACH) && (iabs(ny - ty_q) <= REACH);
        score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        lv        = {3'b000, lfsr_q[9:0]};
        if (lv > L_LIM) lv = lv - 13'sd512;
        mv        = {4'b0000, lfsr_q[15:7]};
        if (mv > M_LIM) mv = mv - 13'sd128;
        tx_new    = HT + lv;
        ty_new    = HT + mv;
    end

    // Game FSM next state and datapath next values.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        hold_d  = hold_q;
        score_d = score_q;
        case (state_q)
            ST_READY: begin
                px_d = X_CTR;
                py_d = Y_CTR;
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = 8'd0;
                    hold_d  = 16'd0;
                    tx_d    = tx_new;
                    ty_d    = ty_new;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    px_d = nx;
                    py_d = ny;
                    if (overlap) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = 16'd0;
                            score_d = score_inc;
                            if (score_inc == WIN_SC) begin
                                state_d = ST_WIN;
                            end else begin
                                tx_d = tx_new;
                                ty_d = ty_new;
                            end
                        end else begin
                            hold_d = hold_q + 16'd1;
                        end
                    end else begin
                        hold_d = 16'd0;
                    end
                end
            end
            ST_WIN: begin
                if (start) begin
                    state_d = ST_READY;
                    px_d    = X_CTR;
                    py_d    = Y_CTR;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) state_q <= ST_READY;
        else        state_q <= state_d;
    end

    // Position, target, hold counter and score registers.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            px_q    <= X_CTR;
            py_q    <= Y_CTR;
            tx_q    <= '0;
            ty_q    <= '0;
            hold_q  <= 16'd0;
            score_q <= 8'd0;
        end else begin
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            hold_q  <= hold_d;
            score_q <= score_d;
        end
    end

    assign accel_x    = {19'd0, px_q};
    assign accel_y    = {19'd0, py_q};
    assign target_x   = {19'd0, tx_q};
    assign target_y   = {19'd0, ty_q};
    assign game_state = {30'd0, state_q};
    assign score      = score_q;

endmodule

// File: tb/tb_square_game_logic.sv
// Directed bench for square_game_logic: idle, button, motion, capture, win and reset scenarios.
// Latency: checks sample 1 time unit after the rising edge that applies each update.
// Backpressure: none; the bench drives inputs freely.
module tb_square_game_logic;

    logic               clk_25mHz = 1'b0;
    logic               reset     = 1'b1;
    logic               screenEnd = 1'b0;
    logic signed [11:0] tilt_x    = '0;
    logic signed [11:0] tilt_y    = '0;
    logic               BTNU      = 1'b0;
    logic [31:0]        accel_x, accel_y, target_x, target_y, game_state;
    logic [7:0]         score;

    int nerr = 0;
    int nchk = 0;

    // Reference game state maintained by the bench.
    int estate, ex, ey, etx, ety, ehold, escore;
    logic [15:0] m;

    square_game_logic dut (
        .clk_25mHz (clk_25mHz),
        .reset     (reset),
        .screenEnd (screenEnd),
        .tilt_x    (tilt_x),
        .tilt_y    (tilt_y),
        .BTNU      (BTNU),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .target_x  (target_x),
        .target_y  (target_y),
        .game_state(game_state),
        .score     (score)
    );

    always #20 clk_25mHz = ~clk_25mHz;

    // Reference random sequence (taps 16,14,13,11 -> mask bits 15,13,12,10).
    always @(posedge clk_25mHz or negedge reset) begin
        if (!reset) m <= 16'hACE1;
        else        m <= {m[14:0], ^(m & 16'hB400)};
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int step_of(input int t);
        if (t <= 16 && t >= -16) return 0;
        return t >>> 6;
    endfunction

    function automatic int tgt_x(input logic [15:0] v);
        int l;
        l = int'(v[9:0]);
        if (l > 579) l -= 512;
        return 30 + l;
    endfunction

    function automatic int tgt_y(input logic [15:0] v);
        int l;
        l = int'(v[15:7]);
        if (l > 419) l -= 128;
        return 30 + l;
    endfunction

    task automatic reset_model();
        estate = 2; ex = 320; ey = 240; etx = 0; ety = 0; ehold = 0; escore = 0;
    endtask

    task automatic tick();
        @(posedge clk_25mHz);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, game_state, estate);
        chk({tag, ".x"}, accel_x, ex);
        chk({tag, ".y"}, accel_y, ey);
        chk({tag, ".tx"}, target_x, etx);
        chk({tag, ".ty"}, target_y, ety);
        chk({tag, ".score"}, score, escore);
    endtask

    // One frame: pulse screenEnd, let the update land, advance the reference, compare.
    task automatic frame(input int tx, input int ty, input string tag);
        logic [15:0] snap;
        tilt_x = 12'(tx);
        tilt_y = 12'(ty);
        screenEnd = 1'b1;
        tick();
        snap = m;
        screenEnd = 1'b0;
        tick();
        if (estate == 1) begin
            ex = clampi(ex + step_of(tx), 25, 614);
            ey = clampi(ey + step_of(ty), 25, 454);
            if (iabs(ex - etx) <= 5 && iabs(ey - ety) <= 5) begin
                ehold++;
                if (ehold == 30) begin
                    ehold = 0;
                    if (escore < 255) escore++;
                    if (escore == 5) estate = 0;
                    else begin
                        etx = tgt_x(snap);
                        ety = tgt_y(snap);
                    end
                end
            end else begin
                ehold = 0;
            end
        end
        check_all(tag);
    endtask

    // Button press held for 3 + extra cycles, then released.
    task automatic press(input int extra);
        logic [15:0] snap;
        BTNU = 1'b1;
        tick();
        tick();
        snap = m;
        tick();
        if (estate == 2) begin
            estate = 1; escore = 0; ehold = 0;
            etx = tgt_x(snap);
            ety = tgt_y(snap);
        end else if (estate == 0) begin
            estate = 2; ex = 320; ey = 240;
        end
        check_all("press");
        repeat (extra) tick();
        BTNU = 1'b0;
        repeat (4) tick();
    endtask

    task automatic steer(input int gx, input int gy);
        int n;
        n = 0;
        while ((ex != gx || ey != gy) && n < 60) begin
            frame(64 * clampi(gx - ex, -31, 31), 64 * clampi(gy - ey, -31, 31), "steer");
            n++;
        end
        chk("steer.reach_x", accel_x, gx);
        chk("steer.reach_y", accel_y, gy);
    endtask

    // Park 10 px beside the target, step onto it and hold; optionally break the hold at frame 29.
    task automatic capture(input bit brk);
        int s0, dir, gx;
        gx = (etx < 320) ? etx + 10 : etx - 10;
        steer(gx, ety);
        s0  = escore;
        dir = (etx > ex) ? 640 : -640;
        frame(dir, 0, "in");
        repeat (28) frame(0, 0, "hold");
        chk("hold29.score", score, s0);
        if (brk) begin
            frame(-dir, 0, "brk");
            chk("brk.score", score, s0);
            frame(dir, 0, "back");
            repeat (28) frame(0, 0, "hold2");
            chk("hold2_29.score", score, s0);
        end
        frame(0, 0, "cap");
        chk("cap.score", score, s0 + 1);
        if (s0 + 1 < 5) begin
            chk("cap.tx_range", 32'(target_x >= 30 && target_x <= 609), 1);
            chk("cap.ty_range", 32'(target_y >= 30 && target_y <= 449), 1);
        end
    endtask

    initial begin
        int saved_x, saved_y, saved_tx;
        reset_model();
        #2 reset = 1'b0;
        #1 check_all("rst");
        repeat (3) tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) frame(0, 0, "idle");

        // Long button hold: a single start; later presses during play do nothing.
        press(997);
        chk("start.state", game_state, 1);
        press(5);
        press(5);
        chk("btn_play.state", game_state, 1);

        for (int k = 1; k <= 40; k++) begin
            frame(640, 0, "sweep");
            chk("sweep.x_hand", accel_x, (320 + 10 * k > 614) ? 614 : 320 + 10 * k);
        end
        for (int k = 0; k < 3; k++) begin
            frame(16, -16, "dead");
            chk("dead.x_hand", accel_x, 614);
        end
        for (int k = 1; k <= 5; k++) begin
            frame(-64, 0, "slow");
            chk("slow.x_hand", accel_x, 614 - k);
        end

        capture(1'b1);
        capture(1'b0);
        capture(1'b0);
        chk("pre_arst.score", score, 3);

        // Asynchronous reset in the middle of a clock period.
        tick();
        #5 reset = 1'b0;
        reset_model();
        #1 check_all("arst");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) frame(0, 0, "post_rst");

        press(0);
        for (int i = 0; i < 5; i++) capture(1'b0);
        chk("win.state", game_state, 0);
        saved_x  = ex;
        saved_y  = ey;
        saved_tx = etx;
        for (int i = 0; i < 3; i++) begin
            frame(640, 640, "frozen");
            chk("frozen.x_hand", accel_x, saved_x);
            chk("frozen.y_hand", accel_y, saved_y);
            chk("frozen.tx_hand", target_x, saved_tx);
            chk("frozen.score_hand", score, 5);
        end
        press(0);
        chk("ready.state", game_state, 2);
        chk("ready.x", accel_x, 320);
        chk("ready.y", accel_y, 240);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
